// File: rtl/riscv_pkg.sv
// Shared front-end definitions: instruction constants, the issue unit's pcDelta
// encoding and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    // PCD_BACK4: only word 0 issued, so word 1 becomes the new word 0 (pair moves +4).
    localparam logic [1:0] PCD_HOLD  = 2'd0;
    localparam logic [1:0] PCD_BACK4 = 2'd1;
    localparam logic [1:0] PCD_FWD8  = 2'd2;

    typedef enum logic [1:0] {
        FS_BUBBLE = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALT   = 2'd2
    } fetch_state_e;

    // Encoding 3 is reserved and treated as a full-pair advance.
    function automatic logic [31:0] pc_step(input logic [1:0] pcDelta);
        case (pcDelta)
            PCD_HOLD:  pc_step = 32'd0;
            PCD_BACK4: pc_step = 32'd4;
            PCD_FWD8:  pc_step = 32'd8;
            default:   pc_step = 32'd8;
        endcase
    endfunction

endpackage

// File: rtl/dual_fetch_stage_if.sv
// Fetch-stage bus: execute redirect, issue back-pressure/pcDelta, instruction
// memory read port and the registered pair presented to the issue unit.
interface dual_fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             redirect;
    logic [31:0]      redirectPc;
    logic [1:0]       pcDelta;
    logic [31:0]      imemAddr;
    logic [31:0]      imemData1;
    logic [31:0]      imemData2;
    logic [31:0]      inst1;
    logic [31:0]      inst2;
    logic [31:0]      pc1;
    logic [31:0]      pc2;
    logic             pairValid;
    logic             fetchFault;
    logic [CNT_W-1:0] bubbleCount;

    modport slave (
        input  stall, redirect, redirectPc, pcDelta, imemData1, imemData2,
        output imemAddr, inst1, inst2, pc1, pc2, pairValid, fetchFault, bubbleCount
    );

    modport master (
        output stall, redirect, redirectPc, pcDelta, imemData1, imemData2,
        input  imemAddr, inst1, inst2, pc1, pc2, pairValid, fetchFault, bubbleCount
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Next-pair address: advance from the held pair by the issue unit's pcDelta,
// or retry pc1 when the held pair is a bubble.
module fetch_next_pc
    import riscv_pkg::*;
(
    input  logic [31:0] pc1,
    input  logic        pairValid,
    input  logic [1:0]  pcDelta,
    output logic [31:0] imemAddr
);

    assign imemAddr = pairValid ? (pc1 + pc_step(pcDelta)) : pc1;

endmodule

// File: rtl/dual_fetch_stage.sv
// Dual-issue fetch stage: owns the PC, fetches an aligned pair per cycle and
// registers it for the issue unit; handles execute redirects and back-pressure.
//
// state     | meaning
// FS_BUBBLE | held pair invalid (after reset or redirect), instructions are zero
// FS_RUN    | held pair valid
// FS_HALT   | misaligned redirect seen; everything frozen until reset
module dual_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_fetch_stage_if.slave   fif
);

    fetch_state_e     state, state_nxt;
    logic [31:0]      pc1_q;
    logic [31:0]      inst1_q;
    logic [31:0]      inst2_q;
    logic             fault_q;
    logic [CNT_W-1:0] bcnt_q;
    logic [31:0]      next_addr;
    logic             pair_valid;
    logic             misaligned;

    assign pair_valid = (state == FS_RUN);
    assign misaligned = (fif.redirectPc[1:0] != 2'b00);

    // Only pcDelta reaches imemAddr combinationally; redirect/stall act at the edge.
    fetch_next_pc u_next_pc (
        .pc1       (pc1_q),
        .pairValid (pair_valid),
        .pcDelta   (fif.pcDelta),
        .imemAddr  (next_addr)
    );

    always_comb begin
        state_nxt = state;
        if (state != FS_HALT) begin
            if (fif.redirect && misaligned) begin
                state_nxt = FS_HALT;
            end else if (fif.redirect) begin
                state_nxt = FS_BUBBLE;
            end else if (!fif.stall) begin
                state_nxt = FS_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FS_BUBBLE;
            pc1_q   <= RESET_PC;
            inst1_q <= BUBBLE_INST;
            inst2_q <= BUBBLE_INST;
            fault_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state != FS_HALT) begin
                if (!pair_valid && (bcnt_q != '1)) begin
                    bcnt_q <= bcnt_q + 1'b1;
                end
                if (fif.redirect) begin
                    inst1_q <= BUBBLE_INST;
                    inst2_q <= BUBBLE_INST;
                    if (misaligned) begin
                        fault_q <= 1'b1;
                    end else begin
                        pc1_q <= fif.redirectPc;
                    end
                end else if (!fif.stall) begin
                    pc1_q   <= next_addr;
                    inst1_q <= fif.imemData1;
                    inst2_q <= fif.imemData2;
                end
            end
        end
    end

    assign fif.imemAddr    = next_addr;
    assign fif.inst1       = inst1_q;
    assign fif.inst2       = inst2_q;
    assign fif.pc1         = pc1_q;
    assign fif.pc2         = pc1_q + 32'd4;
    assign fif.pairValid   = pair_valid;
    assign fif.fetchFault  = fault_q;
    assign fif.bubbleCount = bcnt_q;

endmodule

// File: tb/tb_dual_fetch_stage.sv
// Directed bench for dual_fetch_stage: instruction memory returns an ADDI word
// whose immediate encodes the word address, so each fetched word is traceable.
module tb_dual_fetch_stage;

    localparam int CNT_W = 6;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dual_fetch_stage_if #(.CNT_W(CNT_W)) fif ();

    dual_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[13:2], 20'h00013};
    endfunction

    assign fif.imemData1 = mem_word(fif.imemAddr);
    assign fif.imemData2 = mem_word(fif.imemAddr + 32'd4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        fif.stall      = 1'b0;
        fif.redirect   = 1'b0;
        fif.redirectPc = 32'h0;
        fif.pcDelta    = 2'd2;
        #12;
        checks++; if (fif.pairValid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", fif.pairValid); end
        checks++; if (fif.pc1 !== 32'h0) begin errors++; $display("FAIL reset_pc1 got %h exp 0", fif.pc1); end
        checks++; if (fif.pc2 !== 32'h4) begin errors++; $display("FAIL reset_pc2 got %h exp 4", fif.pc2); end
        checks++; if (fif.inst1 !== 32'h0 || fif.inst2 !== 32'h0) begin errors++; $display("FAIL reset_inst got %h %h exp 0 0", fif.inst1, fif.inst2); end
        checks++; if (fif.fetchFault !== 1'b0 || fif.bubbleCount !== 6'd0) begin errors++; $display("FAIL reset_flags got %b %0d exp 0 0", fif.fetchFault, fif.bubbleCount); end
        checks++; if (fif.imemAddr !== 32'h0) begin errors++; $display("FAIL reset_imem got %h exp 0", fif.imemAddr); end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = 32'(i * 8);
            checks++; if (fif.pc1 !== exp_pc || fif.pc2 !== exp_pc + 32'd4) begin errors++; $display("FAIL run_pc[%0d] got %h %h exp %h", i, fif.pc1, fif.pc2, exp_pc); end
            checks++; if (fif.pairValid !== 1'b1 || fif.inst1 !== mem_word(exp_pc) || fif.inst2 !== mem_word(exp_pc + 32'd4)) begin errors++; $display("FAIL run_inst[%0d] got %b %h %h", i, fif.pairValid, fif.inst1, fif.inst2); end
        end
        checks++; if (fif.bubbleCount !== 6'd1) begin errors++; $display("FAIL run_bcnt got %0d exp 1", fif.bubbleCount); end
        checks++; if (fif.imemAddr !== 32'h18) begin errors++; $display("FAIL run_imem got %h exp 18", fif.imemAddr); end
    endtask

    task automatic test_delta1();
        fif.redirect = 1'b1; fif.redirectPc = 32'h40;
        tick();
        fif.redirect = 1'b0;
        checks++; if (fif.pairValid !== 1'b0 || fif.pc1 !== 32'h40) begin errors++; $display("FAIL d1_redirect got %b %h exp 0 40", fif.pairValid, fif.pc1); end
        tick();
        checks++; if (fif.pairValid !== 1'b1 || fif.pc1 !== 32'h40 || fif.bubbleCount !== 6'd2) begin errors++; $display("FAIL d1_fetch got %b %h %0d exp 1 40 2", fif.pairValid, fif.pc1, fif.bubbleCount); end
        fif.pcDelta = 2'd1;
        tick();
        checks++; if (fif.pc1 !== 32'h44 || fif.inst1 !== mem_word(32'h44) || fif.inst2 !== mem_word(32'h48)) begin errors++; $display("FAIL d1_step got %h %h %h exp 44", fif.pc1, fif.inst1, fif.inst2); end
    endtask

    task automatic test_redirect_stall();
        fif.redirect = 1'b1; fif.redirectPc = 32'h100;
        tick();
        fif.redirect = 1'b0;
        tick();
        checks++; if (fif.pc1 !== 32'h100 || fif.pairValid !== 1'b1 || fif.bubbleCount !== 6'd3) begin errors++; $display("FAIL rs_setup got %h %b %0d exp 100 1 3", fif.pc1, fif.pairValid, fif.bubbleCount); end
        fif.redirect = 1'b1; fif.redirectPc = 32'h200; fif.stall = 1'b1;
        tick();
        fif.redirect = 1'b0; fif.stall = 1'b0;
        checks++; if (fif.pairValid !== 1'b0 || fif.inst1 !== 32'h0 || fif.inst2 !== 32'h0 || fif.bubbleCount !== 6'd3) begin errors++; $display("FAIL rs_flush got %b %h %h %0d", fif.pairValid, fif.inst1, fif.inst2, fif.bubbleCount); end
        tick();
        checks++; if (fif.pc1 !== 32'h200 || fif.pairValid !== 1'b1 || fif.inst1 !== mem_word(32'h200) || fif.bubbleCount !== 6'd4) begin errors++; $display("FAIL rs_target got %h %b %h %0d exp 200 1 4", fif.pc1, fif.pairValid, fif.inst1, fif.bubbleCount); end
    endtask

    task automatic test_stall();
        logic [1:0] deltas [3];
        deltas = '{2'd1, 2'd2, 2'd0};
        fif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fif.pcDelta = deltas[i];
            tick();
            checks++; if (fif.pc1 !== 32'h200 || fif.inst1 !== mem_word(32'h200) || fif.inst2 !== mem_word(32'h204) || fif.pairValid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %h %h %h", i, fif.pc1, fif.inst1, fif.inst2); end
        end
        fif.stall = 1'b0; fif.pcDelta = 2'd2;
        tick();
        checks++; if (fif.pc1 !== 32'h208 || fif.inst1 !== mem_word(32'h208)) begin errors++; $display("FAIL stall_release got %h exp 208", fif.pc1); end
        fif.pcDelta = 2'd0;
        tick();
        checks++; if (fif.pc1 !== 32'h208 || fif.pairValid !== 1'b1 || fif.inst2 !== mem_word(32'h20c) || fif.bubbleCount !== 6'd4) begin errors++; $display("FAIL refetch got %h %b %0d exp 208 1 4", fif.pc1, fif.pairValid, fif.bubbleCount); end
    endtask

    task automatic test_wrap();
        fif.redirect = 1'b1; fif.redirectPc = 32'hFFFF_FFF8;
        tick();
        fif.redirect = 1'b0; fif.pcDelta = 2'd2;
        tick();
        checks++; if (fif.pc1 !== 32'hFFFF_FFF8 || fif.pc2 !== 32'hFFFF_FFFC || fif.bubbleCount !== 6'd5) begin errors++; $display("FAIL wrap_top got %h %h %0d", fif.pc1, fif.pc2, fif.bubbleCount); end
        checks++; if (fif.imemAddr !== 32'h0) begin errors++; $display("FAIL wrap_imem got %h exp 0", fif.imemAddr); end
        fif.pcDelta = 2'd3;
        #1;
        checks++; if (fif.imemAddr !== 32'h0) begin errors++; $display("FAIL wrap_rsvd got %h exp 0", fif.imemAddr); end
        tick();
        checks++; if (fif.pc1 !== 32'h0 || fif.pc2 !== 32'h4 || fif.inst1 !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_next got %h %h %h exp 0 4", fif.pc1, fif.pc2, fif.inst1); end
        fif.redirect = 1'b1; fif.redirectPc = 32'hFFFF_FFFC;
        tick();
        checks++; if (fif.pc1 !== 32'hFFFF_FFFC || fif.pc2 !== 32'h0 || fif.pairValid !== 1'b0) begin errors++; $display("FAIL wrap_pc2 got %h %h %b", fif.pc1, fif.pc2, fif.pairValid); end
    endtask

    task automatic test_fault();
        fif.redirectPc = 32'h202;
        tick();
        checks++; if (fif.fetchFault !== 1'b1 || fif.pairValid !== 1'b0 || fif.inst1 !== 32'h0 || fif.pc1 !== 32'hFFFF_FFFC || fif.bubbleCount !== 6'd6) begin errors++; $display("FAIL fault_entry got %b %b %h %0d", fif.fetchFault, fif.pairValid, fif.pc1, fif.bubbleCount); end
        fif.redirectPc = 32'h300;
        tick();
        fif.redirect = 1'b0;
        tick();
        checks++; if (fif.pc1 !== 32'hFFFF_FFFC || fif.pairValid !== 1'b0 || fif.fetchFault !== 1'b1 || fif.bubbleCount !== 6'd6) begin errors++; $display("FAIL fault_frozen got %h %b %b %0d", fif.pc1, fif.pairValid, fif.fetchFault, fif.bubbleCount); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fif.pc1 !== 32'h0 || fif.fetchFault !== 1'b0 || fif.bubbleCount !== 6'd0 || fif.pairValid !== 1'b0 || fif.imemAddr !== 32'h0) begin errors++; $display("FAIL fault_async_reset got %h %b %0d %b %h", fif.pc1, fif.fetchFault, fif.bubbleCount, fif.pairValid, fif.imemAddr); end
    endtask

    task automatic test_saturate();
        fif.stall = 1'b1; fif.redirect = 1'b0; fif.pcDelta = 2'd2;
        #1;
        rst_n = 1'b1;
        repeat (62) tick();
        checks++; if (fif.bubbleCount !== 6'd62) begin errors++; $display("FAIL sat_count got %0d exp 62", fif.bubbleCount); end
        tick();
        checks++; if (fif.bubbleCount !== 6'd63) begin errors++; $display("FAIL sat_max got %0d exp 63", fif.bubbleCount); end
        repeat (7) tick();
        checks++; if (fif.bubbleCount !== 6'd63 || fif.pairValid !== 1'b0 || fif.pc1 !== 32'h0) begin errors++; $display("FAIL sat_hold got %0d %b %h exp 63 0 0", fif.bubbleCount, fif.pairValid, fif.pc1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run();
        test_delta1();
        test_redirect_stall();
        test_stall();
        test_wrap();
        test_fault();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
